// File: rtl/pwm_fade_ctrl.sv
// LED fade controller: ramps duty_cycle up to a latched peak, holds, then ramps down.
// Define PWM_FADE_LOOP_EN to make the fade repeat continuously until stop is requested.
module pwm_fade_ctrl #(
    parameter int TICK_DIV   = 25000,
    parameter int HOLD_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] step,
    input  logic [7:0] max_duty,
    output logic [7:0] duty_cycle,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, RISE, HOLD, FALL} state_t;

    state_t            state;
    logic [CNT_W-1:0]  tick_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [3:0]        step_lat;
    logic [7:0]        max_lat;
    logic              tick;
    logic [7:0]        rise_nxt;
    logic [7:0]        fall_nxt;
`ifdef PWM_FADE_LOOP_EN
    logic              stopping;
`endif

    // Sum is formed 9 bits wide so a large step near 255 saturates instead of wrapping.
    function automatic logic [7:0] sat_rise(input logic [7:0] d, input logic [3:0] s,
                                            input logic [7:0] m);
        logic [8:0] sum;
        sum = {1'b0, d} + {5'b0, s};
        if (sum >= {1'b0, m})
            return m;
        return sum[7:0];
    endfunction

    function automatic logic [7:0] sat_fall(input logic [7:0] d, input logic [3:0] s);
        if (d > {4'b0, s})
            return d - {4'b0, s};
        return 8'd0;
    endfunction

    assign tick     = (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign rise_nxt = sat_rise(duty_cycle, step_lat, max_lat);
    assign fall_nxt = sat_fall(duty_cycle, step_lat);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            duty_cycle <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tick_cnt   <= '0;
            hold_cnt   <= '0;
            step_lat   <= 4'd1;
            max_lat    <= 8'd0;
`ifdef PWM_FADE_LOOP_EN
            stopping   <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    hold_cnt <= '0;
`ifdef PWM_FADE_LOOP_EN
                    stopping <= 1'b0;
`endif
                    if (start && !stop) begin
                        step_lat <= (step == 4'd0) ? 4'd1 : step;
                        max_lat  <= max_duty;
                        if (max_duty == 8'd0) begin
                            done <= 1'b1;
                        end else begin
                            state <= RISE;
                            busy  <= 1'b1;
                        end
                    end
                end
                RISE: begin
                    if (stop) begin
                        state    <= FALL;
                        tick_cnt <= '0;
`ifdef PWM_FADE_LOOP_EN
                        stopping <= 1'b1;
`endif
                    end else if (tick) begin
                        duty_cycle <= rise_nxt;
                        if (rise_nxt == max_lat) begin
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end
                    end
                end
                HOLD: begin
                    if (stop) begin
                        state    <= FALL;
                        tick_cnt <= '0;
                        hold_cnt <= '0;
`ifdef PWM_FADE_LOOP_EN
                        stopping <= 1'b1;
`endif
                    end else if (tick) begin
                        if (hold_cnt == HOLD_W'(HOLD_TICKS - 1)) begin
                            state    <= FALL;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                FALL: begin
`ifdef PWM_FADE_LOOP_EN
                    if (stop)
                        stopping <= 1'b1;
`endif
                    if (tick) begin
                        duty_cycle <= fall_nxt;
                        if (fall_nxt == 8'd0) begin
`ifdef PWM_FADE_LOOP_EN
                            // Breathing continues until a stop has been seen on the way down.
                            if (stopping || stop) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= RISE;
                            end
`else
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`endif
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl with TICK_DIV=4, HOLD_TICKS=2: table of fade profiles
// plus hand-written abort, reset, zero-peak, stop/start priority and (with PWM_FADE_LOOP_EN) loop runs.
module tb_pwm_fade_ctrl;

    localparam int TD = 4;
    localparam int HT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] step = 4'd0;
    logic [7:0] max_duty = 8'd0;
    logic [7:0] duty_cycle;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    pwm_fade_ctrl #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
        .max_duty(max_duty), .duty_cycle(duty_cycle), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  step;
        logic [7:0]  max;
        logic [3:0]  len;    // number of duty changes in the whole profile
        logic [3:0]  rises;  // how many of those changes happen while rising
        logic [47:0] seq;    // expected duty values, first change in the low byte
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Starts a fade and compares every duty change (value and cycle), the done pulse and busy length.
    task automatic run_vec(input int idx, input vec_t v);
        int   t_end, n_seen, dones, busy_cycles, overlap, over_max, exp_t, done_t;
        logic [7:0] prev;
        t_end       = TD * int'(v.len) + TD * HT;
        n_seen      = 0;
        dones       = 0;
        done_t      = -1;
        busy_cycles = 1;  // the cycle in which start is presented
        overlap     = 0;
        over_max    = 0;
        prev        = duty_cycle;
        step        = v.step;
        max_duty    = v.max;
        start       = 1'b1;
        cyc();
        start       = 1'b0;
        for (int t = 0; t <= t_end + 3; t++) begin
            if (t > 0) cyc();
            if (busy) busy_cycles++;
            if (busy && done) overlap++;
            if (duty_cycle > v.max) over_max++;
            if (done) begin
                dones++;
                done_t = t;
            end
            if (duty_cycle != prev) begin
                if (n_seen < int'(v.len)) begin
                    exp_t = (n_seen < int'(v.rises)) ? TD * (n_seen + 1) : TD * (n_seen + 1) + TD * HT;
                    chk($sformatf("vec%0d_val%0d", idx, n_seen), duty_cycle, v.seq[n_seen*8 +: 8]);
                    chk($sformatf("vec%0d_time%0d", idx, n_seen), t, exp_t);
                end
                n_seen++;
                prev = duty_cycle;
            end
        end
        chk($sformatf("vec%0d_nchanges", idx), n_seen, v.len);
        chk($sformatf("vec%0d_done_count", idx), dones, 1);
        chk($sformatf("vec%0d_done_time", idx), done_t, t_end);
        chk($sformatf("vec%0d_busy_cycles", idx), busy_cycles, t_end + 1);
        chk($sformatf("vec%0d_busy_done_overlap", idx), overlap, 0);
        chk($sformatf("vec%0d_over_max", idx), over_max, 0);
    endtask

    initial begin
        vecs[0] = '{4'd4,  8'd12, 4'd6, 4'd3, {8'd0, 8'd4, 8'd8, 8'd12, 8'd8, 8'd4}};
        vecs[1] = '{4'd15, 8'd20, 4'd4, 4'd2, {16'd0, 8'd0, 8'd5, 8'd20, 8'd15}};
        vecs[2] = '{4'd0,  8'd2,  4'd4, 4'd2, {16'd0, 8'd0, 8'd1, 8'd2, 8'd1}};
        vecs[3] = '{4'd1,  8'd3,  4'd6, 4'd3, {8'd0, 8'd1, 8'd2, 8'd3, 8'd2, 8'd1}};
        vecs[4] = '{4'd8,  8'd7,  4'd2, 4'd1, {32'd0, 8'd0, 8'd7}};

        repeat (3) cyc();
        chk("reset_duty", duty_cycle, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        cyc();

`ifndef PWM_FADE_LOOP_EN
        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
            repeat (2) cyc();
        end
`else
        // Breathing: 4@4, 8@8, 4@20, 0@24, 4@28, 8@32; stop at 33 -> 4@38, 0@42 with done.
        begin
            int lt [8] = '{4, 8, 20, 24, 28, 32, 38, 42};
            int lv [8] = '{4, 8, 4, 0, 4, 8, 4, 0};
            int k = 0;
            int early_done = 0;
            step = 4'd4;
            max_duty = 8'd8;
            start = 1'b1;
            cyc();
            start = 1'b0;
            for (int t = 0; t <= 44; t++) begin
                if (t > 0) cyc();
                if (k < 8 && t == lt[k]) begin
                    chk($sformatf("loop_duty_t%0d", t), duty_cycle, lv[k]);
                    k++;
                end
                if (done && t != 42) early_done++;
                if (t == 42) begin
                    chk("loop_final_done", done, 1);
                    chk("loop_final_busy", busy, 0);
                end
                if (t == 33) stop = 1'b1;
                else stop = 1'b0;
            end
            chk("loop_spurious_done", early_done, 0);
            repeat (2) cyc();
        end
`endif

        // Abort during RISE at duty 8, then a start during FALL that must be ignored.
        step = 4'd4;
        max_duty = 8'd200;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (8) cyc();
        chk("abort_pre_duty", duty_cycle, 8);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("abort_fall_duty", duty_cycle, 8);
        chk("abort_fall_busy", busy, 1);
        cyc();
        start = 1'b1;
        max_duty = 8'd50;
        cyc();
        start = 1'b0;
        cyc();
        chk("abort_t12_duty", duty_cycle, 8);
        cyc();
        chk("abort_t13_duty", duty_cycle, 4);
        repeat (4) cyc();
        chk("abort_t17_duty", duty_cycle, 0);
        chk("abort_t17_done", done, 1);
        chk("abort_t17_busy", busy, 0);
        cyc();
        chk("abort_t18_done", done, 0);
        chk("abort_t18_busy", busy, 0);
        chk("abort_t18_duty", duty_cycle, 0);

        // Reset while in HOLD, with start asserted alongside.
        step = 4'd4;
        max_duty = 8'd8;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (10) cyc();
        chk("rsthold_pre_duty", duty_cycle, 8);
        rst = 1'b1;
        start = 1'b1;
        cyc();
        rst = 1'b0;
        start = 1'b0;
        chk("rsthold_duty", duty_cycle, 0);
        chk("rsthold_busy", busy, 0);
        chk("rsthold_done", done, 0);
        cyc();
        chk("rsthold_after_done", done, 0);
        chk("rsthold_after_busy", busy, 0);

        // Zero peak: no fade, single done pulse.
        max_duty = 8'd0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("zero_peak_done", done, 1);
        chk("zero_peak_busy", busy, 0);
        cyc();
        chk("zero_peak_done_clear", done, 0);
        chk("zero_peak_busy_after", busy, 0);
        chk("zero_peak_duty", duty_cycle, 0);

        // stop wins over start in IDLE.
        max_duty = 8'd8;
        start = 1'b1;
        stop = 1'b1;
        cyc();
        start = 1'b0;
        stop = 1'b0;
        chk("stop_prio_busy", busy, 0);
        chk("stop_prio_done", done, 0);
        cyc();
        chk("stop_prio_busy2", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 25000, giving clk cycles per fade tick (1 ms at 25 MHz); legal range is 2 or more.
REQ-002 The block SHALL have parameter HOLD_TICKS, default 250, giving the number of ticks spent at peak duty; legal range is 1 or more.
REQ-003 Port clk: input, 1 bit, single 25 MHz clock; all logic is on posedge clk.
REQ-004 Port rst: input, 1 bit, synchronous, active-high reset.
REQ-005 Port start: input, 1 bit, single-cycle request to begin a fade sequence.
REQ-006 Port stop: input, 1 bit, single-cycle request to abort to fade-out.
REQ-007 Port step: input, 4 bits, duty change per tick; a value of 0 is treated as 1.
REQ-008 Port max_duty: input, 8 bits, peak duty value.
REQ-009 Port duty_cycle: output, 8 bits, registered duty value that feeds the PWM generator.
REQ-010 Port busy: output, 1 bit, high in every state except IDLE.
REQ-011 Port done: output, 1 bit, single-cycle pulse when a sequence completes.

Function
REQ-012 The block SHALL implement four states: IDLE, RISE, HOLD and FALL.
REQ-013 On start=1 in IDLE with stop=0, the block SHALL latch step and max_duty, then enter RISE on the next edge; busy=1 from that edge onward.
- If latched max_duty=0, it SHALL instead stay in IDLE and pulse done one cycle later.
REQ-014 start SHALL be ignored while busy=1; step and max_duty changes SHALL be ignored while busy=1.
REQ-015 Tick counter:
- Cleared in IDLE and on every state entry.
- Counts 0 to TICK_DIV-1 while busy, then wraps to 0.
- tick is asserted for the one cycle where count equals TICK_DIV-1.
REQ-016 RISE, on each tick: duty_cycle becomes min(duty_cycle+step, max_duty), computed 9 bits wide and saturating, never wrapping.
- When the new value equals max_duty, the state SHALL become HOLD.
REQ-017 HOLD: duty_cycle SHALL stay constant; after HOLD_TICKS ticks, the state SHALL become FALL.
REQ-018 FALL, on each tick: duty_cycle becomes duty_cycle-step if duty_cycle>step, otherwise 0.
- When the new value equals 0, the state SHALL become IDLE, with done=1 for exactly the first IDLE cycle.
REQ-019 stop=1 in RISE or HOLD SHALL move the state to FALL on the next edge, with duty_cycle unchanged and the tick counter cleared.
- stop in FALL or IDLE SHALL have no effect.
- stop has priority over start in the same cycle.
REQ-020 duty_cycle SHALL change only on tick edges; it never exceeds latched max_duty and never underflows below 0.
REQ-021 done and busy SHALL never both be 1 in the same cycle.

Reset
REQ-022 While rst=1 at posedge clk, the block SHALL set: state IDLE, duty_cycle=0, busy=0, done=0, tick counter 0, hold counter 0, latched step 1, latched max_duty 0.
REQ-023 rst SHALL override start and stop in the same cycle.
- Reset mid-sequence SHALL drop duty_cycle to 0 immediately, with no fade and no done pulse.

Configuration
REQ-024 Macro PWM_FADE_LOOP_EN:
- When defined, reaching duty 0 in FALL SHALL go directly to RISE, using the same latched values and with no done pulse, so the block breathes continuously until stop, after which it ends in IDLE with a done pulse.
- When undefined, the block SHALL be one-shot as in REQ-018.

Verification
REQ-025 Bench parameters SHALL be TICK_DIV=4 and HOLD_TICKS=2 for all scenarios below.
REQ-026 Basic sequence: rst, then start with step=4 and max_duty=12.
- Expected duty_cycle sequence: 0, 4, 8, 12, hold for 8 cycles, 8, 4, 0.
- Expected done pulse 1 cycle after duty reaches 0; busy high for 1+3*4+2*4+3*4 cycles total.
REQ-027 Saturation: step=15, max_duty=20.
- Expected duty_cycle sequence: 15, 20 (saturated, never 30), then 5, 0.
REQ-028 step=0 with max_duty=2: expected duty_cycle sequence 1, 2, hold, 1, 0.
REQ-029 Abort: stop issued during RISE at duty=8 (step=4, max_duty=200).
- FALL is entered next cycle; duty 8 falls to 4, then 0 at 4-cycle spacing; one done pulse.
- A start issued during FALL is ignored.
REQ-030 Reset and zero peak:
- rst asserted in HOLD: next cycle duty_cycle=0, busy=0, done=0.
- Then start with max_duty=0: busy stays 0 and done pulses once.
REQ-031 With PWM_FADE_LOOP_EN defined, step=4, max_duty=8: duty_cycle cycles 4, 8, 4, 0, 4, ... with no done pulse until stop, then a done pulse after duty returns to 0.
